// File: rtl/ej32_dstack.sv
// eJ32 data stack: NOS and N2 in registers, deeper entries in a single-write-port
// memory with a registered read of entry 3, plus depth tracking and sticky error flags.
module ej32_dstack #(
   parameter int unsigned DSZ      = 32,
   parameter int unsigned SS_DEPTH = 32,
   parameter int unsigned SPZ      = $clog2(SS_DEPTH) + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [2:0]     op,
   input  logic [DSZ-1:0] t_i,
   input  logic           clr_err,
   output logic [DSZ-1:0] s_o,
   output logic [DSZ-1:0] n2_o,
   output logic [SPZ-1:0] depth_o,
   output logic           full_o,
   output logic           empty_o,
   output logic           ovf_o,
   output logic           udf_o
);

   localparam int unsigned AW = $clog2(SS_DEPTH);
   localparam int unsigned MD = SS_DEPTH - 2;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_POP   = 3'd1,
      OP_PUSH  = 3'd2,
      OP_MOVE  = 3'd3,
      OP_SWAPN = 3'd4
   } op_e;

   logic [DSZ-1:0] mem [MD];

   logic [DSZ-1:0] s_q, s_d, n2_q, n2_d, rd_q, rd_d;
   logic [SPZ-1:0] depth_q, depth_d;
   logic           ovf_q, ovf_d, udf_q, udf_d;
   logic           full_c, empty_c, set_ovf, set_udf, mem_we;
   logic [AW-1:0]  mem_waddr, rd_addr;

   assign full_c  = (depth_q == SPZ'(SS_DEPTH));
   assign empty_c = (depth_q == '0);

   // Next-state logic; rd_q always mirrors entry 3 (mem[depth-3]) or 0 when depth < 3
   always_comb begin
      s_d       = s_q;
      n2_d      = n2_q;
      rd_d      = rd_q;
      depth_d   = depth_q;
      set_ovf   = 1'b0;
      set_udf   = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = '0;
      rd_addr   = '0;
      if (en) begin
         case (op)
            OP_PUSH: begin
               if (full_c) begin
                  set_ovf = 1'b1;
               end else begin
                  mem_we    = (depth_q >= SPZ'(2));
                  mem_waddr = AW'(depth_q - SPZ'(2));
                  n2_d      = s_q;
                  s_d       = t_i;
                  depth_d   = depth_q + SPZ'(1);
                  // new entry 3 is the word being written this cycle
                  rd_d      = (depth_q >= SPZ'(2)) ? n2_q : '0;
               end
            end
            OP_POP: begin
               if (empty_c) begin
                  set_udf = 1'b1;
               end else begin
                  s_d     = n2_q;
                  n2_d    = rd_q;
                  depth_d = depth_q - SPZ'(1);
                  if (depth_q >= SPZ'(4)) begin
                     rd_addr = AW'(depth_q - SPZ'(4));
                     rd_d    = mem[rd_addr];
                  end else begin
                     rd_d    = '0;
                  end
               end
            end
            OP_MOVE: begin
               if (empty_c) set_udf = 1'b1;
               else         s_d     = t_i;
            end
            OP_SWAPN: begin
               if (depth_q < SPZ'(2)) begin
                  set_udf = 1'b1;
               end else begin
                  s_d  = n2_q;
                  n2_d = s_q;
               end
            end
            default: ;
         endcase
      end
      ovf_d = set_ovf | (ovf_q & ~clr_err);
      udf_d = set_udf | (udf_q & ~clr_err);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q     <= '0;
         n2_q    <= '0;
         rd_q    <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         s_q     <= s_d;
         n2_q    <= n2_d;
         rd_q    <= rd_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Single write port; contents are not cleared by reset
   always_ff @(posedge clk) begin
      if (!rst && mem_we) mem[mem_waddr] <= n2_q;
   end

   assign s_o     = s_q;
   assign n2_o    = n2_q;
   assign depth_o = depth_q;
   assign full_o  = full_c;
   assign empty_o = empty_c;
   assign ovf_o   = ovf_q;
   assign udf_o   = udf_q;

endmodule

// File: tb/tb_ej32_dstack.sv
// Directed self-checking bench for ej32_dstack (DSZ=32, SS_DEPTH=32).
module tb_ej32_dstack;

   localparam int unsigned DSZ = 32;
   localparam int unsigned SPZ = 6;

   logic           clk = 1'b0;
   logic           rst, en, clr_err;
   logic [2:0]     op;
   logic [DSZ-1:0] t_i;
   logic [DSZ-1:0] s_o, n2_o;
   logic [SPZ-1:0] depth_o;
   logic           full_o, empty_o, ovf_o, udf_o;

   int errs   = 0;
   int checks = 0;
   int unsigned q[$];

   ej32_dstack dut (
      .clk(clk), .rst(rst), .en(en), .op(op), .t_i(t_i), .clr_err(clr_err),
      .s_o(s_o), .n2_o(n2_o), .depth_o(depth_o), .full_o(full_o),
      .empty_o(empty_o), .ovf_o(ovf_o), .udf_o(udf_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input logic [2:0] o, input logic [31:0] t, input logic c,
                       input logic e, input logic r);
      @(negedge clk);
      op = o; t_i = t; clr_err = c; en = e; rst = r;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] v); step(3'd2, v, 1'b0, 1'b1, 1'b0); endtask
   task automatic pop();                      step(3'd1, 0, 1'b0, 1'b1, 1'b0); endtask

   task automatic check_state(input string tag, input logic [31:0] es, input logic [31:0] en2,
                              input logic [31:0] ed);
      check({tag, ".s"}, s_o, es);
      check({tag, ".n2"}, n2_o, en2);
      check({tag, ".depth"}, 32'(depth_o), ed);
   endtask

   task automatic check_model(input string tag);
      check_state(tag, (q.size() > 0) ? q[0] : 0, (q.size() > 1) ? q[1] : 0, q.size());
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; en = 1'b0; clr_err = 1'b0; op = 3'd0; t_i = '0;
      step(3'd0, 0, 1'b0, 1'b0, 1'b1);
      step(3'd0, 0, 1'b0, 1'b0, 1'b0);
      check_state("reset", 0, 0, 0);
      check("reset.ovf", 32'(ovf_o), 0);
      check("reset.udf", 32'(udf_o), 0);
      check("reset.empty", 32'(empty_o), 1);
      check("reset.full", 32'(full_o), 0);

      // 1) basic push/pop
      for (int i = 1; i <= 5; i++) push(i);
      check_state("t1.push5", 5, 4, 5);
      pop(); pop(); pop();
      check_state("t1.pop3", 2, 1, 2);
      pop();
      check_state("t1.pop4", 1, 0, 1);
      pop();
      check_state("t1.pop5", 0, 0, 0);

      // 2) fill, overflow, drain
      for (int i = 1; i <= 32; i++) push(i);
      check("t2.full", 32'(full_o), 1);
      push(99);
      check("t2.ovf", 32'(ovf_o), 1);
      check_state("t2.after_ovf", 32, 31, 32);
      for (int i = 32; i >= 1; i--) begin
         check("t2.drain.s", s_o, i);
         check("t2.drain.n2", n2_o, i - 1);
         pop();
      end
      check("t2.empty", 32'(empty_o), 1);
      check("t2.ovf_held", 32'(ovf_o), 1);

      // 3) underflow and flag clearing
      pop();
      check("t3.udf", 32'(udf_o), 1);
      check_state("t3.udf_state", 0, 0, 0);
      step(3'd1, 0, 1'b1, 1'b1, 1'b0);
      check("t3.set_beats_clr", 32'(udf_o), 1);
      step(3'd0, 0, 1'b1, 1'b1, 1'b0);
      check("t3.clr.udf", 32'(udf_o), 0);
      check("t3.clr.ovf", 32'(ovf_o), 0);

      // 4) MOVE and SWAPN
      push(32'hA); push(32'hB); push(32'hC);
      step(3'd3, 32'hD, 1'b0, 1'b1, 1'b0);
      check_state("t4.move", 32'hD, 32'hB, 3);
      step(3'd4, 0, 1'b0, 1'b1, 1'b0);
      check_state("t4.swapn", 32'hB, 32'hD, 3);
      pop();
      check_state("t4.pop1", 32'hD, 32'hA, 2);
      pop();
      check_state("t4.pop2", 32'hA, 0, 1);
      step(3'd4, 0, 1'b0, 1'b1, 1'b0);
      check("t4.swapn_udf", 32'(udf_o), 1);
      check_state("t4.swapn_nochg", 32'hA, 0, 1);
      step(3'd0, 0, 1'b1, 1'b1, 1'b0);
      pop();
      check_state("t4.empty", 0, 0, 0);

      // 5) alternating push/pop at depth 3..5 (write/read bypass)
      for (int i = 0; i < 3; i++) begin
         push(10 + i); q.push_front(10 + i);
      end
      check_model("t5.base");
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 8; k++) begin
            // pattern P O P P O P O O keeps depth within 3..5
            if (k == 0 || k == 2 || k == 3 || k == 5) begin
               push(100 + 10 * r + k); q.push_front(100 + 10 * r + k);
            end else begin
               pop(); void'(q.pop_front());
            end
            check_model("t5.alt");
         end
      end
      step(3'd2, 32'h55, 1'b0, 1'b0, 1'b0);
      check_model("t5.en0");
      step(3'd1, 0, 1'b0, 1'b1, 1'b0); void'(q.pop_front());
      check_model("t5.pop_after_en0");
      push(12); q.push_front(12);

      // 6) reset mid-sequence at depth 7
      for (int i = 0; i < 4; i++) push(200 + i);
      check("t6.depth7", 32'(depth_o), 7);
      step(3'd2, 32'h77, 1'b0, 1'b1, 1'b1);
      check_state("t6.rst", 0, 0, 0);
      check("t6.rst.ovf", 32'(ovf_o), 0);
      check("t6.rst.udf", 32'(udf_o), 0);
      push(7);
      check_state("t6.push7", 7, 0, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
